// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions and the hex glyph table.
// Segment vectors are {g,f,e,d,c,b,a}, so bit 0 is segment a.
package seg7_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;
    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_encoder.sv
// Combinational hex-nibble to segment encoder with a blanking override.
// Also used by the single-digit display path.
module seg7_hex_encoder (
    input  logic       [3:0] nibble,
    input  logic             blank,
    output logic       [6:0] seg_c
);
    import seg7_pkg::*;

    always_comb begin
        seg_c = blank ? 7'd0 : hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: shadow/active value registers, per-slot
// dead time, PWM brightness and leading-zero blanking. All outputs registered.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned PWM_BITS   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [PWM_BITS-1:0]     brightness,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_start
);
    import seg7_pkg::*;

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    logic [PRE_W-1:0]    presc;
    logic [IDX_W-1:0]    idx;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] bright_q;
    logic [VAL_W-1:0]    shadow;
    logic [VAL_W-1:0]    active;
    logic                pending;

    logic                presc_tc_c;
    logic                wrap_c;
    logic [3:0]          nib_c;
    logic                blank_c;
    logic [6:0]          seg_c;
    logic [NUM_DIGITS-1:0] lz_c;

    assign presc_tc_c = (presc == PRE_W'(SCAN_DIV - 1));
    assign wrap_c     = presc_tc_c && (idx == IDX_W'(NUM_DIGITS - 1));

    // lz_c[k]: digit k and every digit above it are zero
    always_comb begin
        lz_c = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            lz_c[k] = ((active >> (4 * k)) == '0);
        end
    end

    always_comb begin
        nib_c   = 4'(active >> {idx, 2'b00});
        blank_c = blank_lz && (idx != '0) && lz_c[idx];
    end

    seg7_hex_encoder u_enc (
        .nibble (nib_c),
        .blank  (blank_c),
        .seg_c  (seg_c)
    );

    // Content and brightness only change at the frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            bright_q    <= '0;
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
            seg         <= '0;
            dp          <= 1'b0;
            dig_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            presc       <= presc_tc_c ? '0 : presc + PRE_W'(1);
            pwm_cnt     <= pwm_cnt + PWM_BITS'(1);
            frame_start <= wrap_c;
            if (presc_tc_c) begin
                idx <= wrap_c ? '0 : idx + IDX_W'(1);
            end
            if (wrap_c) begin
                bright_q <= brightness;
                pending  <= 1'b0;
                if (load) begin
                    active <= value_in;
                end else if (pending) begin
                    active <= shadow;
                end
            end else if (load) begin
                shadow  <= value_in;
                pending <= 1'b1;
            end
            seg    <= seg_c;
            dp     <= dp_in[idx];
            dig_en <= ((presc != '0) && (pwm_cnt <= bright_q)) ? (NUM_DIGITS'(1) << idx) : '0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 8-cycle slots, 3-bit PWM).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  dp_in;
    logic [2:0]  brightness;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_en;
    logic        frame_start;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [6:0]  exp_seg [4];
    int          ld_j [2];
    logic [15:0] ld_v [2];
    int          br_j;
    logic [2:0]  br_v;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (8),
        .PWM_BITS   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .load        (load),
        .dp_in       (dp_in),
        .brightness  (brightness),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dp          (dp),
        .dig_en      (dig_en),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input int j, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at step %0d: observed %0h expected %0h", tag, j, obs, exp);
    endtask

    // One frame starting just after a boundary. Slot cycle c equals the PWM phase
    // because both counters restart together at reset and SCAN_DIV == 2**PWM_BITS.
    task automatic run_frame(input logic [2:0] br, input int n);
        int c;
        int d;
        logic [3:0] e_en;
        for (int j = 1; j <= n; j++) begin
            load = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (j == ld_j[i]) begin
                    load     = 1'b1;
                    value_in = ld_v[i];
                end
            end
            if (j == br_j) brightness = br_v;
            @(negedge clk);
            load = 1'b0;
            c = (j - 1) % 8;
            d = (j - 1) / 8;
            e_en = ((c != 0) && (c <= int'(br))) ? 4'(1 << d) : 4'b0000;
            chk("seg", j, 32'(seg), 32'(exp_seg[d]));
            chk("dig_en", j, 32'(dig_en), 32'(e_en));
            chk("dp", j, 32'(dp), 32'(dp_in[d]));
            chk("frame_start", j, 32'(frame_start), 32'(j == 32));
        end
    endtask

    task automatic clear_stim();
        ld_j[0] = 0; ld_j[1] = 0;
        ld_v[0] = 16'h0; ld_v[1] = 16'h0;
        br_j = 0; br_v = 3'd0;
    endtask

    initial begin
        rst = 1'b1; value_in = 16'h0; load = 1'b0; dp_in = 4'b0000;
        brightness = 3'd7; blank_lz = 1'b0;
        clear_stim();
        repeat (3) @(negedge clk);
        chk("rst_seg", 0, 32'(seg), 32'h0);
        chk("rst_dp", 0, 32'(dp), 32'h0);
        chk("rst_dig_en", 0, 32'(dig_en), 32'h0);
        chk("rst_frame_start", 0, 32'(frame_start), 32'h0);
        rst = 1'b0;

        // Frame after release: active=0, latched brightness still 0; load 12AF pending
        exp_seg = '{7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        ld_j[0] = 5; ld_v[0] = 16'h12AF;
        run_frame(3'd0, 32);

        // 12AF at full duty; mid-frame loads and brightness change must wait
        clear_stim();
        exp_seg = '{7'b1110001, 7'b1110111, 7'b1011011, 7'b0000110};
        ld_j[0] = 20; ld_v[0] = 16'h0000;
        ld_j[1] = 22; ld_v[1] = 16'h0005;
        br_j = 10; br_v = 3'd1;
        run_frame(3'd7, 32);

        // 0005 at brightness 1: only the slot cycle right after dead time is lit
        clear_stim();
        exp_seg = '{7'b1101101, 7'b0111111, 7'b0111111, 7'b0111111};
        ld_j[0] = 3; ld_v[0] = 16'h0400;
        br_j = 5; br_v = 3'd7;
        run_frame(3'd1, 32);

        // 0400 with blanking: inner zero kept, top zero blanked (dp still follows dp_in)
        clear_stim();
        blank_lz = 1'b1;
        dp_in = 4'b1010;
        exp_seg = '{7'b0111111, 7'b0111111, 7'b1100110, 7'b0000000};
        ld_j[0] = 8;  ld_v[0] = 16'h1234;
        ld_j[1] = 32; ld_v[1] = 16'h9999;
        run_frame(3'd7, 32);

        // Boundary load shows 9999 immediately; reset while digit 2 is lit
        clear_stim();
        dp_in = 4'b0101;
        exp_seg = '{7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111};
        run_frame(3'd7, 20);
        #2 rst = 1'b1;
        #1;
        chk("arst_seg", 0, 32'(seg), 32'h0);
        chk("arst_dp", 0, 32'(dp), 32'h0);
        chk("arst_dig_en", 0, 32'(dig_en), 32'h0);
        chk("arst_frame_start", 0, 32'(frame_start), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Restart at digit 0 with active=0; higher zeros blanked
        clear_stim();
        exp_seg = '{7'b0111111, 7'b0000000, 7'b0000000, 7'b0000000};
        run_frame(3'd0, 32);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
